// File: rtl/snake_pkg.sv
// Shared types for the snake game blocks: move directions, game state and
// the reversal helper used by the direction latch.
package snake_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } direction;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  function automatic direction opposite(input direction d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head tile for one move, with either wrap-around or an out-of-bounds flag.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int MAP_WIDTH  = 32,
  parameter int MAP_HEIGHT = 24,
  parameter bit WRAP       = 1'b0,
  localparam int XW = $clog2(MAP_WIDTH),
  localparam int YW = $clog2(MAP_HEIGHT)
)(
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  direction      dir,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny,
  output logic          oob
);

  localparam logic [XW-1:0] XMAX = XW'(MAP_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(MAP_HEIGHT - 1);

  // y grows downward, so UP decrements the row
  always_comb begin
    nx  = x;
    ny  = y;
    oob = 1'b0;
    case (dir)
      UP:
        if (y == '0) begin ny = YMAX; oob = !WRAP; end
        else ny = y - 1'b1;
      DOWN:
        if (y == YMAX) begin ny = '0; oob = !WRAP; end
        else ny = y + 1'b1;
      LEFT:
        if (x == '0) begin nx = XMAX; oob = !WRAP; end
        else nx = x - 1'b1;
      RIGHT:
        if (x == XMAX) begin nx = '0; oob = !WRAP; end
        else nx = x + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_engine.sv
// Single snake held as a coordinate ring buffer; one tile per step pulse,
// with growth, wall-kill or wrap, reversal rejection and self-collision.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAP_WIDTH    = 32,
  parameter int MAP_HEIGHT   = 24,
  parameter int MAX_LENGTH   = 64,
  parameter int START_LENGTH = 3,
  parameter int START_X      = 10,
  parameter int START_Y      = 10,
  parameter bit WRAP         = 1'b0,
  localparam int XW = $clog2(MAP_WIDTH),
  localparam int YW = $clog2(MAP_HEIGHT),
  localparam int LW = $clog2(MAX_LENGTH + 1),
  localparam int NC = MAP_WIDTH * MAP_HEIGHT
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  direction      dir,
  input  logic          food_valid,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y,
  output logic [LW-1:0] length,
  output direction      heading,
  output logic [NC-1:0] occ,
  output logic          ate,
  output game_state_t   state
);

  localparam int PW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam int OW = $clog2(NC);

  logic [XW-1:0] ring_x [MAX_LENGTH];
  logic [YW-1:0] ring_y [MAX_LENGTH];
  logic [PW-1:0] head_ptr, tail_ptr;
  direction      pending;

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          oob;
  logic [OW-1:0] nidx, tidx;
  logic          grow, at_tail, hit, keep_tail, dir_ok;

  snake_next_head #(
    .MAP_WIDTH (MAP_WIDTH),
    .MAP_HEIGHT(MAP_HEIGHT),
    .WRAP      (WRAP)
  ) u_next_head (
    .x  (head_x),
    .y  (head_y),
    .dir(pending),
    .nx (nx),
    .ny (ny),
    .oob(oob)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LENGTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tail_x    = ring_x[tail_ptr];
  assign tail_y    = ring_y[tail_ptr];
  assign nidx      = OW'(ny) * OW'(MAP_WIDTH) + OW'(nx);
  assign tidx      = OW'(tail_y) * OW'(MAP_WIDTH) + OW'(tail_x);
  assign grow      = food_valid && (nx == food_x) && (ny == food_y);
  assign at_tail   = (nx == tail_x) && (ny == tail_y);
  // the tail cell is about to be vacated unless this step grows the snake
  assign hit       = occ[nidx] && !(at_tail && !grow);
  assign keep_tail = grow && (length < LW'(MAX_LENGTH));
  assign dir_ok    = (dir != NONE) && (dir != opposite(heading));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < START_LENGTH; k++) begin
        ring_x[k] <= XW'(START_X);
        ring_y[k] <= YW'(START_Y + START_LENGTH - 1 - k);
      end
      occ <= '0;
      for (int k = 0; k < START_LENGTH; k++)
        occ[(START_Y + k) * MAP_WIDTH + START_X] <= 1'b1;
      head_x   <= XW'(START_X);
      head_y   <= YW'(START_Y);
      head_ptr <= PW'(START_LENGTH - 1);
      tail_ptr <= '0;
      length   <= LW'(START_LENGTH);
      heading  <= UP;
      pending  <= UP;
      state    <= IDLE;
      ate      <= 1'b0;
    end else begin
      ate <= 1'b0;
      if (state != DEAD) begin
        if (dir_ok) pending <= dir;
        case (state)
          IDLE: if (dir_ok || pending != heading) state <= RUN;
          RUN: if (step) begin
            if (oob || hit) begin
              state <= DEAD;
            end else begin
              head_ptr                 <= ptr_inc(head_ptr);
              ring_x[ptr_inc(head_ptr)] <= nx;
              ring_y[ptr_inc(head_ptr)] <= ny;
              head_x  <= nx;
              head_y  <= ny;
              heading <= pending;
              ate     <= grow;
              if (keep_tail) begin
                length <= length + 1'b1;
              end else begin
                occ[tidx] <= 1'b0;
                tail_ptr  <= ptr_inc(tail_ptr);
              end
              // after the tail clear so a head entering the old tail cell wins
              occ[nidx] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
